// File: rtl/alu_mul_seq.sv
// alu_mul_seq: multi-cycle unsigned dw x dw shift-and-add multiplier.
// Drives an external registered ALU for every partial-product add. The
// 2*dw-bit product builds up in {acc, mq}, with one shift per multiplier bit.
module alu_mul_seq #(
  parameter int dw = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [dw-1:0] a,
  input  logic [dw-1:0] b,
  output logic          busy,
  output logic          done,
  output logic [dw-1:0] prod_hi,
  output logic [dw-1:0] prod_lo,
  output logic [3:0]    alu_op,
  output logic [dw-1:0] alu_AI,
  output logic [dw-1:0] alu_BI,
  output logic          alu_CI,
  output logic          alu_RDY,
  input  logic [dw-1:0] alu_OUT,
  input  logic          alu_CO
);

  localparam int CW = (dw > 1) ? $clog2(dw) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(dw - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [3:0]    OP_ADD   = 4'b0011;
  localparam logic [3:0]    OP_NOP   = 4'b1111;
  localparam logic [dw-1:0] ZERO_DW  = {dw{1'b0}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TEST  = 3'd1,
    ADD   = 3'd2,
    CAPT  = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t state_r;
  state_t next_state_s;

  // Datapath registers and their next values
  logic [dw-1:0] a_reg_r, a_reg_s;
  logic [dw-1:0] acc_r,   acc_s;
  logic [dw-1:0] mq_r,    mq_s;
  logic          c_r,     c_s;
  logic [CW-1:0] cnt_r,   cnt_s;

  // Registered outputs
  logic          busy_r;
  logic          done_r;
  logic [dw-1:0] prod_hi_r;
  logic [dw-1:0] prod_lo_r;
  logic [3:0]    alu_op_r;
  logic [dw-1:0] alu_ai_r;
  logic [dw-1:0] alu_bi_r;
  logic          alu_ci_r;
  logic          alu_rdy_r;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode: one TEST/SHIFT pair per bit, plus ADD/CAPT when the bit is set
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = TEST;
        end else begin
          next_state_s = IDLE;
        end
      end
      TEST: begin
        if (mq_r[0]) begin
          next_state_s = ADD;
        end else begin
          next_state_s = SHIFT;
        end
      end
      ADD:   next_state_s = CAPT;
      CAPT:  next_state_s = SHIFT;
      SHIFT: begin
        if (cnt_r == LAST_CNT) begin
          next_state_s = DONE;
        end else begin
          next_state_s = TEST;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Datapath next values; ALU result is consumed only in CAPT, the cycle after ADD
  always_comb begin
    a_reg_s = a_reg_r;
    acc_s   = acc_r;
    mq_s    = mq_r;
    c_s     = c_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          a_reg_s = a;
          mq_s    = b;
          acc_s   = ZERO_DW;
          c_s     = 1'b0;
          cnt_s   = {CW{1'b0}};
        end else begin
          a_reg_s = a_reg_r;
        end
      end
      TEST: begin
        if (mq_r[0]) begin
          c_s = c_r;
        end else begin
          c_s = 1'b0;
        end
      end
      CAPT: begin
        acc_s = alu_OUT;
        c_s   = alu_CO;
      end
      SHIFT: begin
        // The add carry lands in acc[dw-1], so the running sum never overflows
        {c_s, acc_s, mq_s} = {1'b0, c_r, acc_r, mq_r[dw-1:1]};
        if (cnt_r == LAST_CNT) begin
          cnt_s = cnt_r;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ADD:     a_reg_s = a_reg_r;
      DONE:    a_reg_s = a_reg_r;
      default: a_reg_s = a_reg_r;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg_r <= ZERO_DW;
      acc_r   <= ZERO_DW;
      mq_r    <= ZERO_DW;
      c_r     <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else begin
      a_reg_r <= a_reg_s;
      acc_r   <= acc_s;
      mq_r    <= mq_s;
      c_r     <= c_s;
      cnt_r   <= cnt_s;
    end
  end

  // Status and ALU request outputs, registered from the next state so they align with it
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      alu_op_r  <= OP_NOP;
      alu_ai_r  <= ZERO_DW;
      alu_bi_r  <= ZERO_DW;
      alu_ci_r  <= 1'b0;
      alu_rdy_r <= 1'b0;
    end else begin
      busy_r   <= (next_state_s != IDLE);
      done_r   <= (next_state_s == DONE);
      alu_ci_r <= 1'b0;
      if (next_state_s == ADD) begin
        alu_op_r  <= OP_ADD;
        alu_ai_r  <= acc_r;
        alu_bi_r  <= a_reg_r;
        alu_rdy_r <= 1'b1;
      end else begin
        alu_op_r  <= OP_NOP;
        alu_ai_r  <= ZERO_DW;
        alu_bi_r  <= ZERO_DW;
        alu_rdy_r <= 1'b0;
      end
    end
  end

  // Product registers: loaded in DONE and held until the next multiply completes
  always_ff @(posedge clk) begin
    if (reset) begin
      prod_hi_r <= ZERO_DW;
      prod_lo_r <= ZERO_DW;
    end else if (state_r == DONE) begin
      prod_hi_r <= acc_r;
      prod_lo_r <= mq_r;
    end else begin
      prod_hi_r <= prod_hi_r;
      prod_lo_r <= prod_lo_r;
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign prod_hi = prod_hi_r;
  assign prod_lo = prod_lo_r;
  assign alu_op  = alu_op_r;
  assign alu_AI  = alu_ai_r;
  assign alu_BI  = alu_bi_r;
  assign alu_CI  = alu_ci_r;
  assign alu_RDY = alu_rdy_r;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq: a dw=16 instance plus a dw=8 instance,
// each paired with a small registered-adder model of the ALU.
module tb_alu_mul_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // dw=16 instance
  logic        start;
  logic [15:0] a, b;
  logic        busy, done;
  logic [15:0] prod_hi, prod_lo;
  logic [3:0]  alu_op;
  logic [15:0] alu_AI, alu_BI;
  logic        alu_CI, alu_RDY;
  logic [15:0] alu_OUT = 16'h0000;
  logic        alu_CO  = 1'b0;

  alu_mul_seq #(.dw(16)) dut16 (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .prod_hi(prod_hi), .prod_lo(prod_lo),
    .alu_op(alu_op), .alu_AI(alu_AI), .alu_BI(alu_BI), .alu_CI(alu_CI),
    .alu_RDY(alu_RDY), .alu_OUT(alu_OUT), .alu_CO(alu_CO)
  );

  // ALU model: registered AI+BI+CI, updated only when RDY is high
  always @(posedge clk) begin
    if (alu_RDY) {alu_CO, alu_OUT} <= {1'b0, alu_AI} + {1'b0, alu_BI} + {16'h0000, alu_CI};
  end

  // dw=8 instance
  logic       start8;
  logic [7:0] a8, b8;
  logic       busy8, done8;
  logic [7:0] prod_hi8, prod_lo8;
  logic [3:0] alu_op8;
  logic [7:0] alu_AI8, alu_BI8;
  logic       alu_CI8, alu_RDY8;
  logic [7:0] alu_OUT8 = 8'h00;
  logic       alu_CO8  = 1'b0;

  alu_mul_seq #(.dw(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .prod_hi(prod_hi8), .prod_lo(prod_lo8),
    .alu_op(alu_op8), .alu_AI(alu_AI8), .alu_BI(alu_BI8), .alu_CI(alu_CI8),
    .alu_RDY(alu_RDY8), .alu_OUT(alu_OUT8), .alu_CO(alu_CO8)
  );

  // ALU model for the dw=8 instance
  always @(posedge clk) begin
    if (alu_RDY8) {alu_CO8, alu_OUT8} <= {1'b0, alu_AI8} + {1'b0, alu_BI8} + {8'h00, alu_CI8};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Results of the last wait_done call
  int          w_lat, w_pulses;
  logic [15:0] w_ai0, w_bi0, w_ai1, w_bi1;
  logic        w_ok;

  // Called at the negedge of the acceptance cycle t. Walks cycles t+1.. until done,
  // recording ALU requests; at t+1 applies the given start/a/b values.
  task automatic wait_done(input logic nxt_start, input logic [15:0] na, input logic [15:0] nb);
    w_lat = 0; w_pulses = 0; w_ok = 1'b1;
    w_ai0 = 16'h0; w_bi0 = 16'h0; w_ai1 = 16'h0; w_bi1 = 16'h0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = nxt_start; a = na; b = nb;
      end
      if (alu_RDY === 1'b1) begin
        if (w_pulses == 0) begin w_ai0 = alu_AI; w_bi0 = alu_BI; end
        if (w_pulses == 1) begin w_ai1 = alu_AI; w_bi1 = alu_BI; end
        w_pulses++;
        if (alu_op !== 4'b0011) w_ok = 1'b0;
      end else begin
        if (alu_op !== 4'b1111 || alu_AI !== 16'h0 || alu_BI !== 16'h0) w_ok = 1'b0;
      end
      if (alu_CI !== 1'b0 || busy !== 1'b1) w_ok = 1'b0;
      if (done === 1'b1) begin
        w_lat = n;
        break;
      end
    end
  endtask

  // One complete multiply on the dw=16 instance, with start dropped after acceptance
  task automatic run16(input string tag, input logic [15:0] av, input logic [15:0] bv,
                       input logic [15:0] ehi, input logic [15:0] elo,
                       input int elat, input int epulses);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    wait_done(1'b0, av, bv);
    check({tag, "_latency"}, w_lat, elat);
    check({tag, "_pulses"}, w_pulses, epulses);
    check({tag, "_alu_ctrl"}, {31'd0, w_ok}, 32'd1);
    @(negedge clk);
    check({tag, "_prod"}, {prod_hi, prod_lo}, {ehi, elo});
    check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  int lat8;
  int pop8;
  logic ok8;

  initial begin
    reset = 1'b1; start = 1'b0; a = 16'h0; b = 16'h0;
    start8 = 1'b0; a8 = 8'h0; b8 = 8'h0;
    repeat (2) @(negedge clk);
    check("reset_status", {30'd0, busy, done}, 32'd0);
    check("reset_prod", {prod_hi, prod_lo}, 32'h0);
    check("reset_alu_op", {28'd0, alu_op}, 32'hF);
    check("reset_alu_ops", {alu_AI, alu_BI}, 32'h0);
    check("reset_alu_rdy_ci", {30'd0, alu_RDY, alu_CI}, 32'd0);
    reset = 1'b0;

    // 3 x 5: adds at bits 0 and 2, acc is 0 before each add
    run16("m3x5", 16'd3, 16'd5, 16'h0000, 16'h000F, 37, 2);
    check("m3x5_add0", {w_ai0, w_bi0}, {16'h0000, 16'h0003});
    check("m3x5_add1", {w_ai1, w_bi1}, {16'h0000, 16'h0003});

    // b = 0: no ALU requests at all
    run16("mb0", 16'h1234, 16'h0000, 16'h0000, 16'h0000, 33, 0);

    // full-scale: carry path on every bit after the first
    run16("mffff", 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 65, 16);
    check("mffff_add0", {w_ai0, w_bi0}, {16'h0000, 16'hFFFF});
    check("mffff_add1", {w_ai1, w_bi1}, {16'h7FFF, 16'hFFFF});

    // back-to-back with start held high; operands change while busy
    @(negedge clk);
    a = 16'd2; b = 16'd3; start = 1'b1;
    wait_done(1'b1, 16'd7, 16'd9);
    check("b2b1_latency", w_lat, 37);
    check("b2b1_pulses", w_pulses, 2);
    @(negedge clk);
    check("b2b1_prod", {prod_hi, prod_lo}, 32'h0000_0006);
    check("b2b1_gap", {30'd0, busy, done}, 32'd0);
    wait_done(1'b0, 16'd7, 16'd9);
    check("b2b2_latency", w_lat, 37);
    check("b2b2_alu_ctrl", {31'd0, w_ok}, 32'd1);
    @(negedge clk);
    check("b2b2_prod", {prod_hi, prod_lo}, 32'h0000_003F);

    // reset at TEST of bit 7 (cycle t+15 with low byte of b clear)
    @(negedge clk);
    a = 16'h1234; b = 16'h0100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_status", {29'd0, busy, done, alu_RDY}, 32'd0);
    check("abort_prod", {prod_hi, prod_lo}, 32'h0);
    reset = 1'b0;
    run16("post_reset", 16'h1234, 16'h0100, 16'h0012, 16'h3400, 35, 1);

    // dw=8 instance: random operand pairs
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a8 = 8'($urandom_range(0, 255));
      b8 = 8'($urandom_range(0, 255));
      pop8 = $countones(b8);
      start8 = 1'b1;
      lat8 = 0;
      ok8 = 1'b1;
      for (int n = 1; n <= 100; n++) begin
        @(negedge clk);
        start8 = 1'b0;
        if (alu_CI8 !== 1'b0) ok8 = 1'b0;
        if (alu_RDY8 !== 1'b1 && (alu_op8 !== 4'b1111 || alu_AI8 !== 8'h0 || alu_BI8 !== 8'h0)) ok8 = 1'b0;
        if (busy8 !== 1'b1) ok8 = 1'b0;
        if (done8 === 1'b1) begin
          lat8 = n;
          break;
        end
      end
      check("dw8_latency", lat8, 17 + 2 * pop8);
      check("dw8_ctrl", {31'd0, ok8}, 32'd1);
      @(negedge clk);
      check("dw8_prod", {16'd0, prod_hi8, prod_lo8}, {16'd0, 16'(a8) * 16'(b8)});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
